// File: rtl/calc_pkg.sv
// Shared definitions for the calculator accumulator sequencer.
//   - CALC_WIDTH : default datapath width (also the MUL/DIV iteration count)
//   - OP_*       : 3-bit command opcodes; 3'b110 and 3'b111 are illegal
//   - state_t    : sequencer FSM state encoding
//   - op_is_legal: true for the six defined opcodes
package calc_pkg;

  localparam int CALC_WIDTH = 16;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_ITER  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_CLR);
  endfunction

endpackage

// File: rtl/calc_muldiv_iter.sv
// Iterative unsigned multiply / divide engine, one bit per clock.
// A start pulse loads the operands; exactly WIDTH cycles later 'done' is high
// for one cycle while 'result'/'ovf' present the final value.
//   clk, reset : clock and synchronous active-high reset
//   start      : load operands and begin (one-cycle pulse)
//   op_is_div  : 1 = restoring division, 0 = shift-add multiplication
//   a, b       : operands (dividend/multiplicand, divisor/multiplier)
//   result     : low WIDTH bits of A*B, or floor(A/B)
//   ovf        : MUL only - high WIDTH bits of the product are nonzero
//   done       : final iteration cycle; result/ovf are valid
module calc_muldiv_iter
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic               busy_r;
  logic               is_div_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   divisor_r;

  logic [2*WIDTH-1:0] prod_nx;
  logic [2*WIDTH-1:0] mcand_nx;
  logic [WIDTH-1:0]   mplier_nx;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;

  // One iteration step of both algorithms, computed from the current registers.
  always_comb begin
    mcand_nx  = mcand_r << 1;
    mplier_nx = mplier_r >> 1;
    if (mplier_r[0]) begin
      prod_nx = prod_r + mcand_r;
    end else begin
      prod_nx = prod_r;
    end

    // Restoring division: bring down the next dividend bit, subtract if it fits.
    // The difference is always below the divisor, so WIDTH bits suffice.
    shifted_s = {rem_r, quo_r[WIDTH-1]};
    if (shifted_s >= {1'b0, divisor_r}) begin
      rem_nx = shifted_s[WIDTH-1:0] - divisor_r;
      quo_nx = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shifted_s[WIDTH-1:0];
      quo_nx = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Final-cycle outputs come straight from the last step so the caller can
  // register them on the same edge that ends the iteration.
  always_comb begin
    done = busy_r && (cnt_r == CNT_LAST);
    if (is_div_r) begin
      result = quo_nx;
      ovf    = 1'b0;
    end else begin
      result = prod_nx[WIDTH-1:0];
      ovf    = |prod_nx[2*WIDTH-1:WIDTH];
    end
  end

  // Operand load on start, then one step per cycle until the last count.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r    <= 1'b0;
      is_div_r  <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      mcand_r   <= {2*WIDTH{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      prod_r    <= {2*WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      divisor_r <= {WIDTH{1'b0}};
    end else if (start) begin
      busy_r    <= 1'b1;
      is_div_r  <= op_is_div;
      cnt_r     <= {CNT_W{1'b0}};
      mcand_r   <= {{WIDTH{1'b0}}, a};
      mplier_r  <= b;
      prod_r    <= {2*WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      quo_r     <= a;
      divisor_r <= b;
    end else if (busy_r) begin
      mcand_r  <= mcand_nx;
      mplier_r <= mplier_nx;
      prod_r   <= prod_nx;
      rem_r    <= rem_nx;
      quo_r    <= quo_nx;
      cnt_r    <= cnt_r + CNT_W'(1);
      if (done) begin
        busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_acc_sequencer.sv
// Command sequencer for the calculator's accumulator register.
// Accepts one command per CMD_VALID/CMD_READY handshake, computes the new
// accumulator value from the latched ACC_Q and CMD_DATA, writes it back via
// ACC_EN/ACC_D (or ACC_CLR_N for CLR) and pulses DONE with OVF/ERR status.
//   CLK, RESET           : clock, synchronous active-high reset
//   CMD_VALID/READY/OP/DATA : command handshake, opcode and operand B
//   ACC_Q                : current accumulator value (operand A)
//   ACC_D, ACC_EN        : write-back value and one-cycle load enable
//   ACC_CLR_N            : one-cycle active-low clear (INIT and CLR)
//   BUSY, DONE           : not-idle indicator, one-cycle completion pulse
//   OVF, ERR             : status, valid from DONE until the next accept
module calc_acc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [2:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic [WIDTH-1:0] ACC_Q,
  output logic [WIDTH-1:0] ACC_D,
  output logic             ACC_EN,
  output logic             ACC_CLR_N,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF,
  output logic             ERR
);

  state_t state_r;
  state_t next_state;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [2:0]       op_r;
  logic             ovf_r;
  logic             err_r;

  logic             accept_s;
  logic             b_zero_s;
  logic             cmd_err_s;
  logic             eng_start_s;
  logic             eng_done_s;
  logic             eng_ovf_s;
  logic [WIDTH-1:0] eng_result_s;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] diff_s;
  logic             borrow_s;

  logic             ready_nx;
  logic             busy_nx;
  logic             done_nx;
  logic             en_nx;
  logic             clr_n_nx;

  // Handshake and command classification in the accept cycle.
  always_comb begin
    accept_s    = CMD_VALID && (state_r == ST_IDLE);
    b_zero_s    = (CMD_DATA == {WIDTH{1'b0}});
    cmd_err_s   = !op_is_legal(CMD_OP) || ((CMD_OP == OP_DIV) && b_zero_s);
    eng_start_s = accept_s &&
                  ((CMD_OP == OP_MUL) || ((CMD_OP == OP_DIV) && !b_zero_s));
  end

  // Single-cycle EXEC arithmetic on the latched operands.
  always_comb begin
    sum_s    = {1'b0, a_r} + {1'b0, b_r};
    diff_s   = a_r - b_r;
    borrow_s = (a_r < b_r);
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state_r;
    case (state_r)
      ST_INIT: begin
        next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept_s) begin
          if (cmd_err_s) begin
            next_state = ST_DONE;
          end else if (eng_start_s) begin
            next_state = ST_ITER;
          end else begin
            next_state = ST_EXEC;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_EXEC: begin
        next_state = ST_WRITE;
      end
      ST_ITER: begin
        if (eng_done_s) begin
          next_state = ST_WRITE;
        end else begin
          next_state = ST_ITER;
        end
      end
      ST_WRITE: begin
        next_state = ST_DONE;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_INIT;
      end
    endcase
  end

  // Output levels for the upcoming state; registered below so every control
  // output comes from a flop yet lines up with the state it belongs to.
  // op_r is already valid whenever WRITE is next, since WRITE never follows IDLE.
  always_comb begin
    ready_nx = (next_state == ST_IDLE);
    busy_nx  = (next_state != ST_IDLE);
    done_nx  = (next_state == ST_DONE);
    if (next_state == ST_WRITE) begin
      en_nx    = (op_r != OP_CLR);
      clr_n_nx = (op_r != OP_CLR);
    end else if (next_state == ST_INIT) begin
      en_nx    = 1'b0;
      clr_n_nx = 1'b0;
    end else begin
      en_nx    = 1'b0;
      clr_n_nx = 1'b1;
    end
  end

  // State register and registered control outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= ST_INIT;
      CMD_READY <= 1'b0;
      BUSY      <= 1'b1;
      DONE      <= 1'b0;
      ACC_EN    <= 1'b0;
      ACC_CLR_N <= 1'b0;
    end else begin
      state_r   <= next_state;
      CMD_READY <= ready_nx;
      BUSY      <= busy_nx;
      DONE      <= done_nx;
      ACC_EN    <= en_nx;
      ACC_CLR_N <= clr_n_nx;
    end
  end

  // Operand latch, result register and status flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      op_r  <= OP_LOAD;
      res_r <= {WIDTH{1'b0}};
      ovf_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r   <= ACC_Q;
            b_r   <= CMD_DATA;
            op_r  <= CMD_OP;
            ovf_r <= 1'b0;
            err_r <= cmd_err_s;
          end
        end
        ST_EXEC: begin
          case (op_r)
            OP_LOAD: res_r <= b_r;
            OP_ADD: begin
              res_r <= sum_s[WIDTH-1:0];
              ovf_r <= sum_s[WIDTH];
            end
            OP_SUB: begin
              res_r <= diff_s;
              ovf_r <= borrow_s;
            end
            default: res_r <= res_r;
          endcase
        end
        ST_ITER: begin
          if (eng_done_s) begin
            res_r <= eng_result_s;
            ovf_r <= eng_ovf_s;
          end
        end
        default: begin
          res_r <= res_r;
        end
      endcase
    end
  end

  assign ACC_D = res_r;
  assign OVF   = ovf_r;
  assign ERR   = err_r;

  // Operands go straight from the command bus so the engine starts on the
  // accept edge and finishes on the WIDTH-th ITER cycle.
  calc_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (CLK),
    .reset    (RESET),
    .start    (eng_start_s),
    .op_is_div(CMD_OP == OP_DIV),
    .a        (ACC_Q),
    .b        (CMD_DATA),
    .result   (eng_result_s),
    .ovf      (eng_ovf_s),
    .done     (eng_done_s)
  );

endmodule

// File: tb/tb_calc_acc_sequencer.sv
// Scoreboard bench for calc_acc_sequencer: the issuing process predicts each
// command's write-back, flags, final accumulator and DONE cycle from plain
// arithmetic; a negedge monitor pops and compares when ACC_EN/ACC_CLR_N/DONE
// appear. The bench also models the external accumulator register.
module tb_calc_acc_sequencer;

  localparam int W = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          CMD_VALID = 1'b0;
  logic          CMD_READY;
  logic [2:0]    CMD_OP = 3'b000;
  logic [W-1:0]  CMD_DATA = 16'h0000;
  logic [W-1:0]  ACC_Q;
  logic [W-1:0]  ACC_D;
  logic          ACC_EN;
  logic          ACC_CLR_N;
  logic          BUSY;
  logic          DONE;
  logic          OVF;
  logic          ERR;

  logic [W-1:0]  acc_reg = 16'hA5A5;

  typedef struct {
    bit          wr;
    bit          clr;
    logic [15:0] wdata;
    bit          ovf;
    bit          err;
    int          done_at;
    logic [15:0] final_acc;
    bit          seen_wr;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  bit          rst_phase = 1'b1;
  logic [15:0] model_acc = 16'h0000;

  calc_acc_sequencer #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_OP   (CMD_OP),
    .CMD_DATA (CMD_DATA),
    .ACC_Q    (ACC_Q),
    .ACC_D    (ACC_D),
    .ACC_EN   (ACC_EN),
    .ACC_CLR_N(ACC_CLR_N),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .OVF      (OVF),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  // External accumulator register
  always @(posedge CLK) begin
    if (ACC_CLR_N === 1'b0) acc_reg <= 16'h0000;
    else if (ACC_EN === 1'b1) acc_reg <= ACC_D;
  end
  assign ACC_Q = acc_reg;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: new accumulator value and status from plain arithmetic
  function automatic exp_t predict(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input int n);
    exp_t e;
    longint unsigned full;
    e.wr = 0; e.clr = 0; e.wdata = 16'h0000; e.ovf = 0; e.err = 0;
    e.seen_wr = 0; e.final_acc = a; e.done_at = n + 3;
    case (op)
      3'd0: begin e.wr = 1; e.wdata = b; end
      3'd1: begin
        full = longint'(a) + longint'(b);
        e.wr = 1; e.wdata = full[15:0]; e.ovf = (full > 64'd65535);
      end
      3'd2: begin e.wr = 1; e.wdata = a - b; e.ovf = (a < b); end
      3'd3: begin
        full = longint'(a) * longint'(b);
        e.wr = 1; e.wdata = full[15:0]; e.ovf = (full > 64'd65535);
        e.done_at = n + W + 2;
      end
      3'd4: begin
        if (b == 16'h0000) begin
          e.err = 1; e.done_at = n + 1;
        end else begin
          full = longint'(a) / longint'(b);
          e.wr = 1; e.wdata = full[15:0]; e.done_at = n + W + 2;
        end
      end
      3'd5: begin e.clr = 1; e.final_acc = 16'h0000; end
      default: begin e.err = 1; e.done_at = n + 1; end
    endcase
    if (e.wr) e.final_acc = e.wdata;
    return e;
  endfunction

  // Wait for CMD_READY, predict, then drive the command (optionally held longer)
  task automatic issue(input logic [2:0] op, input logic [15:0] d, input int hold);
    exp_t e;
    bit   got;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK); #1;
      if (CMD_READY === 1'b1) begin got = 1; break; end
    end
    if (!got) begin
      check(0, "ready_timeout", {31'd0, CMD_READY}, 32'd1);
      return;
    end
    e = predict(op, model_acc, d, cyc);
    q.push_back(e);
    model_acc = e.final_acc;
    CMD_VALID = 1'b1; CMD_OP = op; CMD_DATA = d;
    @(posedge CLK); #1;
    if (hold > 0) begin
      CMD_OP = 3'b001; CMD_DATA = 16'h1111;
      repeat (hold) @(posedge CLK);
      #1;
    end
    CMD_VALID = 1'b0;
  endtask

  // Two reset edges, then the INIT cycle and the first IDLE cycle are checked
  task automatic apply_reset();
    @(negedge CLK); #1;
    RESET = 1'b1; rst_phase = 1'b1; q.delete(); model_acc = 16'h0000;
    @(posedge CLK);
    @(negedge CLK);
    check(DONE === 1'b0 && ACC_EN === 1'b0, "rst_done_en", {30'd0, DONE, ACC_EN}, 32'd0);
    check(OVF === 1'b0 && ERR === 1'b0, "rst_flags", {30'd0, OVF, ERR}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check(ACC_CLR_N === 1'b0, "init_clr_n", {31'd0, ACC_CLR_N}, 32'd0);
    check(CMD_READY === 1'b0 && BUSY === 1'b1, "init_ready_busy", {30'd0, CMD_READY, BUSY}, 32'd1);
    @(negedge CLK);
    check(ACC_CLR_N === 1'b1, "idle_clr_n", {31'd0, ACC_CLR_N}, 32'd1);
    check(CMD_READY === 1'b1 && BUSY === 1'b0, "idle_ready_busy", {30'd0, CMD_READY, BUSY}, 32'd2);
    check(ACC_Q === 16'h0000, "init_acc_zero", {16'd0, ACC_Q}, 32'd0);
    rst_phase = 1'b0;
  endtask

  // Monitor: compares write-backs and completions against the scoreboard queue
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (ACC_EN === 1'b1) begin
        if (q.size() == 0 || !q[0].wr) begin
          check(0, "acc_en_unexpected", {31'd0, ACC_EN}, 32'd0);
        end else begin
          check(ACC_D === q[0].wdata, "acc_d", {16'd0, ACC_D}, {16'd0, q[0].wdata});
          check(cyc == q[0].done_at - 1, "acc_en_cycle", cyc, q[0].done_at - 1);
          q[0].seen_wr = 1;
        end
      end
      if (ACC_CLR_N === 1'b0 && !rst_phase) begin
        if (q.size() == 0 || !q[0].clr) begin
          check(0, "clr_unexpected", {31'd0, ACC_CLR_N}, 32'd1);
        end else begin
          check(cyc == q[0].done_at - 1, "clr_cycle", cyc, q[0].done_at - 1);
          q[0].seen_wr = 1;
        end
      end
      if (DONE === 1'b1) begin
        if (q.size() == 0) begin
          check(0, "done_unexpected", {31'd0, DONE}, 32'd0);
        end else begin
          e = q.pop_front();
          check(cyc == e.done_at, "done_latency", cyc, e.done_at);
          check(OVF === e.ovf, "ovf", {31'd0, OVF}, {31'd0, e.ovf});
          check(ERR === e.err, "err", {31'd0, ERR}, {31'd0, e.err});
          check(ACC_Q === e.final_acc, "acc_q", {16'd0, ACC_Q}, {16'd0, e.final_acc});
          check(e.seen_wr == (e.wr || e.clr), "write_seen", {31'd0, e.seen_wr}, {31'd0, e.wr || e.clr});
          check(BUSY === 1'b1 && CMD_READY === 1'b0, "done_busy", {30'd0, BUSY, CMD_READY}, 32'd2);
        end
      end
    end
  end

  initial begin
    logic [2:0]  op;
    logic [15:0] d;
    int          r;

    apply_reset();

    // LOAD with CMD_VALID held through the busy cycles
    issue(3'd0, 16'h6AB3, 2);
    repeat (4) @(negedge CLK);
    check(ACC_Q === 16'h6AB3, "held_valid_ignored", {16'd0, ACC_Q}, 32'h6AB3);
    check(q.size() == 0, "held_valid_no_extra", q.size(), 0);

    // ADD / SUB wrap
    issue(3'd0, 16'hFFFF, 0);
    issue(3'd1, 16'h0002, 0);
    issue(3'd0, 16'h0003, 0);
    issue(3'd2, 16'h0005, 0);
    // MUL
    issue(3'd0, 16'h0F00, 0);
    issue(3'd3, 16'h0002, 0);
    issue(3'd0, 16'h0100, 0);
    issue(3'd3, 16'h0100, 0);
    // DIV, divide by zero, illegal opcodes, CLR
    issue(3'd0, 16'h0F00, 0);
    issue(3'd4, 16'h0010, 0);
    issue(3'd0, 16'h6AB3, 0);
    issue(3'd4, 16'h0000, 0);
    issue(3'd7, 16'h1234, 0);
    issue(3'd6, 16'h0001, 0);
    issue(3'd5, 16'h0000, 0);

    // Reset in the middle of a MUL
    issue(3'd0, 16'h0F00, 0);
    issue(3'd3, 16'h0002, 0);
    repeat (7) @(negedge CLK);
    apply_reset();

    // Randomized commands
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 15);
      if (r < 3) op = 3'd0;
      else if (r < 5) op = 3'd1;
      else if (r < 7) op = 3'd2;
      else if (r < 10) op = 3'd3;
      else if (r < 13) op = 3'd4;
      else if (r == 13) op = 3'd5;
      else if (r == 14) op = 3'd6;
      else op = 3'd7;
      if ($urandom_range(0, 3) == 0) d = 16'($urandom_range(0, 20));
      else d = 16'($urandom);
      issue(op, d, 0);
    end

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    check(q.size() == 0, "scoreboard_drained", q.size(), 0);
    check(ACC_Q === model_acc, "final_acc", {16'd0, ACC_Q}, {16'd0, model_acc});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/calc_acc_sequencer.md
Name: calc_acc_sequencer

Overview:
Command-driven controller for the 16-bit accumulator register of the pocket-calculator datapath. It accepts one operation per valid/ready handshake and computes the new value from the latched accumulator value and the command operand. It then writes the result into the accumulator through its enable/clear inputs and reports completion and status flags. It sits between the keypad/command decoder and the accumulator register.

Parameters:
WIDTH, 16, datapath width; also the MUL/DIV iteration count.

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  synchronous, active-high reset
CMD_VALID  in  1  command present
CMD_READY  out  1  sequencer can accept a command
CMD_OP  in  3  opcode (see package)
CMD_DATA  in  WIDTH  operand B
ACC_Q  in  WIDTH  current accumulator output
ACC_D  out  WIDTH  value to load into the accumulator
ACC_EN  out  1  accumulator load enable, one cycle
ACC_CLR_N  out  1  accumulator clear, active-low, one cycle
BUSY  out  1  command in progress or INIT
DONE  out  1  one-cycle completion pulse
OVF  out  1  result overflow/borrow; valid from DONE until the next accept
ERR  out  1  divide-by-zero or illegal opcode; valid from DONE until the next accept

Behaviour:
- Clocking and reset: one clock, CLK. RESET is synchronous and active-high. While RESET is high, the state is INIT, and OVF, ERR, DONE and ACC_EN are all 0.
- States: INIT, IDLE, EXEC, ITER, WRITE, DONE_S.
- INIT: lasts one cycle after RESET deasserts. ACC_CLR_N=0, BUSY=1, CMD_READY=0. Next state is IDLE.
- IDLE: CMD_READY=1, BUSY=0.
- Accept: CMD_VALID&&CMD_READY at an edge.
  - That edge latches A=ACC_Q, B=CMD_DATA and OP.
  - It clears OVF and ERR.
  - CMD_VALID outside IDLE is ignored; nothing is queued.
- Routing after accept:
  - LOAD, ADD, SUB, CLR go to EXEC.
  - MUL, DIV with B!=0 go to ITER.
  - DIV with B==0 goes directly to DONE_S with ERR=1.
  - Opcodes 110/111 go to DONE_S with ERR=1.
- EXEC: 1 cycle; registers the result into RES.
  - LOAD: RES=B.
  - ADD: RES=(A+B) mod 2^16, OVF=carry out.
  - SUB: RES=(A-B) mod 2^16, OVF=borrow (A<B).
  - CLR: no arithmetic.
- ITER: exactly WIDTH cycles, driven by an iteration counter 0..WIDTH-1.
  - MUL: unsigned shift-add. RES=low WIDTH bits of A*B. OVF=1 if the high WIDTH bits are nonzero.
  - DIV: unsigned restoring division. RES=floor(A/B). The remainder is discarded. OVF=0.
- WRITE: 1 cycle. ACC_EN=1 and ACC_D=RES, except for CLR, which drives ACC_CLR_N=0 with ACC_EN=0.
- DONE_S: 1 cycle with DONE=1. ACC_Q already shows the new value. Next state is IDLE.
- Latency from the accept edge to DONE high:
  - simple ops: cycle 3;
  - MUL/DIV: cycle WIDTH+2 (18 at default);
  - error cases: cycle 1.
- Default output levels:
  - ACC_EN=0 outside WRITE.
  - ACC_CLR_N=1 except in INIT and CLR-WRITE.
  - ACC_D equals RES at all times; it is only meaningful when ACC_EN=1.
- BUSY=1 in every state except IDLE.
- RESET mid-operation: the next state is INIT. No ACC_EN or DONE is produced for the aborted command. The accumulator is cleared by INIT.
- Error cases never assert ACC_EN, so the accumulator is unchanged.

Decomposition:
- Package calc_pkg holds:
  - opcode constants: LOAD=000, ADD=001, SUB=010, MUL=011, DIV=100, CLR=101;
  - state encoding;
  - the WIDTH default.
- Sub-module calc_muldiv_iter is the iterative engine.
  - Inputs: start, op_is_div, A, B.
  - Outputs: result, ovf, done after WIDTH cycles.
- The top level holds the FSM, handshake, EXEC adder/subtractor and flags.

Test Plan:
- Reset:
  - Stimulus: RESET high 2 cycles, then low.
  - Required: ACC_CLR_N=0 for exactly one cycle after release, then CMD_READY=1, BUSY=0, ACC_Q=0x0000.
- LOAD:
  - Stimulus: LOAD 0x6AB3.
  - Required: ACC_EN=1 for one cycle with ACC_D=0x6AB3. DONE at accept+3. ACC_Q=0x6AB3. OVF=ERR=0. A second CMD_VALID held during BUSY is not accepted.
- ADD/SUB wrap:
  - ADD 0x0002 with ACC=0xFFFF gives ACC=0x0001, OVF=1.
  - Then LOAD 0x0003 and SUB 0x0005 gives ACC=0xFFFE, OVF=1.
- MUL:
  - ACC=0x0F00, MUL 0x0002 gives 0x1E00, OVF=0, DONE at accept+18.
  - ACC=0x0100, MUL 0x0100 gives 0x0000, OVF=1.
- DIV:
  - ACC=0x0F00, DIV 0x0010 gives 0x00F0.
  - ACC=0x6AB3, DIV 0x0000 gives ERR=1 and DONE at accept+1, with no ACC_EN and ACC unchanged.
  - Opcode 111 gives ERR=1 with no write.
- Reset mid-op:
  - Stimulus: ACC=0x0F00, MUL 0x0002, RESET high at ITER cycle 8.
  - Required: no ACC_EN and no DONE for that command, INIT clears ACC to 0x0000, CMD_READY=1 one cycle after INIT.
